// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Parity modes, FSM states and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic int frame_len(
        input int data_bits,
        input int stop_bits,
        input int parity,
        input int clk_div
    );
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0)
                + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port and status of the buffered UART transmitter.
// The CPU is the master; the transmitter is the slave.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          busy;

    modport master (
        output wr_data, wr_en,
        input  full, level, overflow, busy
    );

    modport slave (
        input  wr_data, wr_en,
        output full, level, overflow, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output.
// Occupancy is tracked by a counter; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter fed by the CPU stdout strobe.
// Writes never stall; a write into a full buffer is dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_if.slave      bus,
    output logic               uart_tx_pin
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [7:0]    MASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam logic [2:0]    D_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    S_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == PARITY_ODD);

    uart_state_t   state;
    logic [TW-1:0] timer;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          ovf_q;

    logic [7:0]    head;
    logic [7:0]    head_m;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          tick;
    logic          stop_end;
    logic          pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_m   = head & MASK;
    assign tick     = (timer == T_LAST);
    assign stop_end = (state == ST_STOP) && tick && (bitcnt == S_LAST);
    assign pop      = !fifo_empty && ((state == ST_IDLE) || stop_end);

    assign bus.full     = fifo_full;
    assign bus.level    = fifo_level;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state != ST_IDLE) || (fifo_level != '0);

    // full is the pre-edge value, so a same-edge pop never rescues the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en && fifo_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            bitcnt      <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            uart_tx_pin <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    uart_tx_pin <= 1'b1;
                    if (pop) begin
                        shift       <= head_m;
                        par_bit     <= (^head_m) ^ ODD;
                        timer       <= '0;
                        bitcnt      <= '0;
                        uart_tx_pin <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        timer       <= '0;
                        uart_tx_pin <= shift[0];
                        state       <= ST_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!tick) begin
                        timer <= timer + 1'b1;
                    end else if (bitcnt == D_LAST) begin
                        timer  <= '0;
                        bitcnt <= '0;
                        if (PARITY != PARITY_NONE) begin
                            uart_tx_pin <= par_bit;
                            state       <= ST_PARITY;
                        end else begin
                            uart_tx_pin <= 1'b1;
                            state       <= ST_STOP;
                        end
                    end else begin
                        timer       <= '0;
                        bitcnt      <= bitcnt + 1'b1;
                        shift       <= shift >> 1;
                        uart_tx_pin <= shift[1];
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        timer       <= '0;
                        uart_tx_pin <= 1'b1;
                        state       <= ST_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!tick) begin
                        timer <= timer + 1'b1;
                    end else if (bitcnt != S_LAST) begin
                        timer  <= '0;
                        bitcnt <= bitcnt + 1'b1;
                    end else if (pop) begin
                        // back-to-back frame: no idle bit between stop and start
                        shift       <= head_m;
                        par_bit     <= (^head_m) ^ ODD;
                        timer       <= '0;
                        bitcnt      <= '0;
                        uart_tx_pin <= 1'b0;
                        state       <= ST_START;
                    end else begin
                        timer       <= '0;
                        bitcnt      <= '0;
                        uart_tx_pin <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    uart_tx_pin <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: five transmitter configurations on one clock.
// Frame waveforms come from hand-written bit strings.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] we;
    logic [7:0] wd [5];
    logic [4:0] line_v;
    logic [4:0] busy_v;
    logic [4:0] full_v;
    logic [4:0] ovf_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) if0 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(16)) if1 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(16)) if2 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(4))  if3 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(16)) if4 ();

    assign if0.wr_en = we[0];
    assign if1.wr_en = we[1];
    assign if2.wr_en = we[2];
    assign if3.wr_en = we[3];
    assign if4.wr_en = we[4];
    assign if0.wr_data = wd[0];
    assign if1.wr_data = wd[1];
    assign if2.wr_data = wd[2];
    assign if3.wr_data = wd[3];
    assign if4.wr_data = wd[4];

    assign busy_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign full_v = {if4.full, if3.full, if2.full, if1.full, if0.full};
    assign ovf_v  = {if4.overflow, if3.overflow, if2.overflow,
                     if1.overflow, if0.overflow};

    uart_tx_fifo #(.CLK_DIV(4)) u0 (
        .clk(clk), .rst(rst), .bus(if0), .uart_tx_pin(line_v[0]));
    uart_tx_fifo #(.CLK_DIV(2), .PARITY(PARITY_ODD)) u1 (
        .clk(clk), .rst(rst), .bus(if1), .uart_tx_pin(line_v[1]));
    uart_tx_fifo #(.CLK_DIV(2), .PARITY(PARITY_EVEN), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2), .uart_tx_pin(line_v[2]));
    uart_tx_fifo #(.CLK_DIV(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .bus(if3), .uart_tx_pin(line_v[3]));
    uart_tx_fifo #(.CLK_DIV(1), .DATA_BITS(5)) u4 (
        .clk(clk), .rst(rst), .bus(if4), .uart_tx_pin(line_v[4]));

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         db;
        int         sb;
        int         par;
        int         cd;
        string      bits;
    } frame_vec_t;

    frame_vec_t vecs [8];

    logic [7:0] seqa [6] = '{8'hA1, 8'h3C, 8'h5A, 8'hF0, 8'h0F, 8'h99};
    int lvl_a  [7] = '{1, 1, 2, 3, 4, 4, 4};
    int full_a [7] = '{0, 0, 0, 0, 1, 1, 1};
    int ovf_a  [7] = '{0, 0, 0, 0, 0, 1, 0};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input frame_vec_t v);
        int   len;
        logic e;
        len = frame_len(v.db, v.sb, v.par, v.cd);
        wd[v.inst] = v.data;
        we[v.inst] = 1'b1;
        @(negedge clk);
        we[v.inst] = 1'b0;
        check($sformatf("v%0d idle-after-write line", idx),
              32'(line_v[v.inst]), 32'd1);
        check($sformatf("v%0d busy-after-write", idx),
              32'(busy_v[v.inst]), 32'd1);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            e = (v.bits[c / v.cd] == 8'h31);
            check($sformatf("v%0d line cyc%0d", idx, c),
                  32'(line_v[v.inst]), 32'(e));
        end
        @(negedge clk);
        check($sformatf("v%0d busy-after-frame", idx),
              32'(busy_v[v.inst]), 32'd0);
        check($sformatf("v%0d line-after-frame", idx),
              32'(line_v[v.inst]), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int inst,
                             input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            done = !busy_v[inst];
        end
        check(name, 32'(done), 32'd1);
    endtask

    function automatic logic exp_line3(input int t);
        int   f;
        int   b;
        logic [7:0] byte_v;
        if (t < 1 || t > 50) return 1'b1;
        f = (t - 1) / 10;
        b = (t - 1) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        byte_v = seqa[f];
        return byte_v[b - 1];
    endfunction

    initial begin
        we = '0;
        for (int i = 0; i < 5; i++) wd[i] = 8'h00;

        vecs[0] = '{0, 8'h55, 8, 1, PARITY_NONE, 4, "0101010101"};
        vecs[1] = '{1, 8'h07, 8, 1, PARITY_ODD,  2, "01110000001"};
        vecs[2] = '{2, 8'h07, 8, 2, PARITY_EVEN, 2, "011100000111"};
        vecs[3] = '{4, 8'hFF, 5, 1, PARITY_NONE, 1, "0111111"};
        vecs[4] = '{0, 8'hA3, 8, 1, PARITY_NONE, 4, "0110001011"};
        vecs[5] = '{1, 8'h80, 8, 1, PARITY_ODD,  2, "00000000101"};
        vecs[6] = '{2, 8'h00, 8, 2, PARITY_EVEN, 2, "000000000011"};
        vecs[7] = '{4, 8'h35, 5, 1, PARITY_NONE, 1, "0101011"};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset line u%0d", i), 32'(line_v[i]), 32'd1);
            check($sformatf("reset busy u%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset full u%0d", i), 32'(full_v[i]), 32'd0);
            check($sformatf("reset ovf u%0d", i),  32'(ovf_v[i]),  32'd0);
        end
        check("reset level u0", 32'(if0.level), 32'd0);
        check("reset level u3", 32'(if3.level), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // six writes into a depth-4 buffer; only the sixth is dropped
        we[3] = 1'b1;
        for (int t = 0; t <= 5 * frame_len(8, 1, PARITY_NONE, 1) + 1; t++) begin
            if (t < 6) wd[3] = seqa[t];
            else       we[3] = 1'b0;
            @(negedge clk);
            if (t <= 6) begin
                check($sformatf("seqA level t%0d", t),
                      32'(if3.level), 32'(lvl_a[t]));
                check($sformatf("seqA full t%0d", t),
                      32'(full_v[3]), 32'(full_a[t]));
                check($sformatf("seqA ovf t%0d", t),
                      32'(ovf_v[3]), 32'(ovf_a[t]));
            end
            check($sformatf("seqA line t%0d", t),
                  32'(line_v[3]), 32'(exp_line3(t)));
            check($sformatf("seqA busy t%0d", t),
                  32'(busy_v[3]), (t <= 50) ? 32'd1 : 32'd0);
        end

        // write into a full buffer on the same edge as a pop
        repeat (2) @(negedge clk);
        for (int t = 0; t <= 12; t++) begin
            wd[3] = 8'hE0 + 8'(t);
            we[3] = (t < 5) || (t == 11);
            @(negedge clk);
            if (t == 10) begin
                check("seqB full before pop", 32'(full_v[3]), 32'd1);
                check("seqB level before pop", 32'(if3.level), 32'd4);
            end
            if (t == 11) begin
                check("seqB ovf on pop edge", 32'(ovf_v[3]), 32'd1);
                check("seqB level after pop", 32'(if3.level), 32'd3);
            end
            if (t == 12) begin
                check("seqB ovf one cycle", 32'(ovf_v[3]), 32'd0);
                check("seqB level steady", 32'(if3.level), 32'd3);
            end
        end
        we[3] = 1'b0;
        wait_idle("seqB drain", 3, 60);

        // reset during the third data bit with two bytes queued
        repeat (2) @(negedge clk);
        for (int t = 0; t <= 14; t++) begin
            wd[0] = (t == 0) ? 8'h12 : (t == 1) ? 8'h34 : 8'h56;
            we[0] = (t < 3);
            @(negedge clk);
        end
        check("rst pre line data bit2", 32'(line_v[0]), 32'd0);
        check("rst pre level", 32'(if0.level), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst line immediate", 32'(line_v[0]), 32'd1);
        check("rst level immediate", 32'(if0.level), 32'd0);
        check("rst busy immediate", 32'(busy_v[0]), 32'd0);
        check("rst full immediate", 32'(full_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (line_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
                check($sformatf("post-rst quiet t%0d", t),
                      32'({line_v[0], busy_v[0]}), 32'b10);
            end
        end
        check("post-rst line", 32'(line_v[0]), 32'd1);
        check("post-rst busy", 32'(busy_v[0]), 32'd0);
        check("post-rst level", 32'(if0.level), 32'd0);

        run_vec(8, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed-format CPU stdout UART transmitter.
- Buffers bytes from the CPU stdout strobe (stdout/stdout_en) in a FIFO and serialises them on uart_tx_pin.
- Data width, stop bits, parity mode, baud divider and buffer depth are configurable.
- The CPU writes without stalling. A byte written while the FIFO is full is dropped and flagged.

Parameters:
- CLK_DIV, 1: clk cycles per serial bit (>=1; 1 gives fastest simulation).
- DATA_BITS, 8: data bits per frame, 5..8, LSB first; wr_data bits above DATA_BITS are ignored.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16: entries, power of two, >=2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_data  input  8  byte to transmit
- wr_en  input  1  write strobe, one byte per cycle high
- full  output  1  FIFO holds FIFO_DEPTH entries
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
- overflow  output  1  one-cycle pulse when a write is dropped
- busy  output  1  high while a frame is in progress or the FIFO is non-empty
- uart_tx_pin  output  1  serial line, idle high

Behaviour:
- Reset (async, immediate):
  - uart_tx_pin=1, full=0, level=0, overflow=0, busy=0.
  - FSM returns to IDLE and the FIFO empties.
  - Reset mid-frame aborts the frame. The line goes high at once. No partial frame resumes after release.
- Write rules:
  - wr_en with full=0 stores the byte at that edge; level increments.
  - wr_en with full=1 drops the byte and pulses overflow for exactly 1 cycle. This holds even if a pop happens at the same edge, because full is evaluated pre-edge.
  - Simultaneous push and pop leaves level unchanged.
- There is no bypass path: every byte passes through the FIFO.
- FSM states:
  - IDLE: line high. If FIFO non-empty, pop the head into the shift register, set bit counter=0, go to START.
  - START: line 0 for CLK_DIV cycles, then DATA.
  - DATA: line = shift[0] for CLK_DIV cycles per bit, shift right. After DATA_BITS bits go to PARITY if PARITY!=0, else STOP.
  - PARITY: line = XOR of the data bits, inverted for odd mode, for CLK_DIV cycles, then STOP.
  - STOP: line 1 for STOP_BITS*CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Latency: a write sampled at edge E0 into an empty FIFO with the FSM in IDLE gives a pop at edge E1. uart_tx_pin is driven low from E1 (registered output).
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles exactly.
- Bit timer: counts 0..CLK_DIV-1 and wraps. With CLK_DIV=1 each bit lasts one cycle.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty are derived from level, not from pointer equality.
- busy = (state!=IDLE) | (level!=0).
- uart_tx_pin is a registered output with no glitches.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - frame_len function used by the bench.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - Ports: push, pop, din, dout, full, empty, level.
  - dout is valid combinationally from the head; pop advances it.
  - Reused by a future UART receiver.

Test Plan:
- CLK_DIV=4, 8N1: write 0x55 into an empty FIFO -> line low 1 cycle after the write edge; bits 0,1,0,1,0,1,0,1,0 then 1 are each held 4 cycles; total frame 40 cycles; busy falls right after the stop bit.
- CLK_DIV=2, PARITY=1 (odd): write 0x07 -> parity bit 0. With PARITY=2 (even) -> parity bit 1. Frame 22 cycles; 2 stop bits give 24 cycles.
- FIFO_DEPTH=4: write 6 bytes on consecutive cycles -> level reaches 4, full=1; the 6th write pulses overflow for 1 cycle. 5 frames go out back-to-back with no idle gap, containing the first 5 bytes in order: one byte is popped at the edge after the first write, so only the 6th write is dropped.
- DATA_BITS=5, CLK_DIV=1: write 0xFF -> exactly 5 data ones between the start and stop bits; frame 7 cycles.
- Assert rst during the 3rd data bit of a frame with 2 bytes queued -> line high immediately, level=0, busy=0. After release the line stays high until a new write arrives.
- Push while full and a pop at the same edge -> byte dropped, overflow pulses, level becomes DEPTH-1.
